// File: rtl/exception_controller.sv
// Prioritised exception/interrupt controller: accepts one of NUM_CAUSES sources,
// captures EPC/Cause, fetches the handler address from a vector table, supports ERET.
module exception_controller #(
    parameter int                     DATA_W      = 32,
    parameter int                     NUM_CAUSES  = 4,
    parameter logic [NUM_CAUSES-1:0]  SYNC_MASK   = 4'b0011,
    parameter logic [DATA_W-1:0]      VECTOR_BASE = 32'd240
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_CAUSES-1:0] exc_req,
    input  logic [NUM_CAUSES-1:0] irq_mask,
    input  logic                  instr_boundary,
    input  logic [DATA_W-1:0]     fault_pc,
    input  logic                  eret,
    output logic                  mem_req,
    output logic [DATA_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  take_exc,
    output logic [DATA_W-1:0]     handler_addr,
    output logic                  ret_valid,
    output logic [DATA_W-1:0]     epc,
    output logic [DATA_W-1:0]     cause,
    output logic [NUM_CAUSES-1:0] pending,
    output logic                  in_handler,
    output logic                  double_fault,
    output logic [1:0]            state_dbg
);

    localparam int IDX_W = (NUM_CAUSES > 1) ? $clog2(NUM_CAUSES) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DISPATCH, HANDLER} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        cause_idx;
    logic [NUM_CAUSES-1:0]   req_all;
    logic [NUM_CAUSES-1:0]   elig;
    logic [NUM_CAUSES-1:0]   clr;
    logic [NUM_CAUSES-1:0]   pending_next;
    logic [IDX_W-1:0]        win_idx;
    logic                    any_elig;

    assign req_all = pending | exc_req;
    assign elig    = req_all & (SYNC_MASK | (irq_mask & {NUM_CAUSES{instr_boundary}}));

    // Lowest eligible index wins; scan downwards so the last hit is the lowest.
    always_comb begin
        win_idx  = '0;
        any_elig = 1'b0;
        for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_idx  = IDX_W'(i);
                any_elig = 1'b1;
            end
        end
    end

    always_comb begin
        clr = '0;
        if (state == IDLE && any_elig) begin
            clr[win_idx] = 1'b1;
        end
    end

    // An arrival is consumed by its own acceptance only when nothing was already
    // pending on that bit; an older pending event being cleared keeps the new one.
    assign pending_next = (pending & ~clr) | (exc_req & ~(clr & ~pending));

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cause_idx    <= '0;
            epc          <= '0;
            handler_addr <= '0;
            pending      <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            busy         <= 1'b0;
            take_exc     <= 1'b0;
            ret_valid    <= 1'b0;
            in_handler   <= 1'b0;
            double_fault <= 1'b0;
        end else begin
            pending   <= pending_next;
            take_exc  <= 1'b0;
            ret_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        epc       <= fault_pc;
                        cause_idx <= win_idx;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        mem_addr  <= VECTOR_BASE + (DATA_W'(win_idx) << 2);
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        handler_addr <= mem_rdata;
                        mem_req      <= 1'b0;
                        busy         <= 1'b0;
                        mem_addr     <= '0;
                        take_exc     <= 1'b1;
                        state        <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    in_handler <= 1'b1;
                    state      <= HANDLER;
                end
                HANDLER: begin
                    if (|(exc_req & SYNC_MASK)) begin
                        double_fault <= 1'b1;
                    end
                    if (eret) begin
                        ret_valid  <= 1'b1;
                        in_handler <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cause     = DATA_W'(cause_idx);
    assign state_dbg = state;

endmodule

// File: tb/tb_exception_controller.sv
// Directed and randomised bench for exception_controller; take_exc events are
// checked against a queue of expected {handler_addr, epc, cause} tuples.
module tb_exception_controller;

    localparam int DATA_W = 32;
    localparam int NC     = 4;
    localparam int EW     = 3 * DATA_W;
    localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_DISP = 2'd2, S_HAND = 2'd3;

    logic              clock = 1'b0;
    logic              reset;
    logic [NC-1:0]     exc_req;
    logic [NC-1:0]     irq_mask;
    logic              instr_boundary;
    logic [DATA_W-1:0] fault_pc;
    logic              eret;
    logic              mem_req;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              busy;
    logic              take_exc;
    logic [DATA_W-1:0] handler_addr;
    logic              ret_valid;
    logic [DATA_W-1:0] epc;
    logic [DATA_W-1:0] cause;
    logic [NC-1:0]     pending;
    logic              in_handler;
    logic              double_fault;
    logic [1:0]        state_dbg;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    exception_controller dut (
        .clock(clock), .reset(reset), .exc_req(exc_req), .irq_mask(irq_mask),
        .instr_boundary(instr_boundary), .fault_pc(fault_pc), .eret(eret),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy), .take_exc(take_exc),
        .handler_addr(handler_addr), .ret_valid(ret_valid), .epc(epc),
        .cause(cause), .pending(pending), .in_handler(in_handler),
        .double_fault(double_fault), .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; exc_req = '0; irq_mask = '0; instr_boundary = 1'b0;
        fault_pc = '0; eret = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] h, input logic [DATA_W-1:0] pc,
                            input int c);
        exp_q.push_back({h, pc, DATA_W'(c)});
    endtask

    // Scoreboard: every take_exc pulse must match the oldest expectation
    always @(negedge clock) begin
        if (!reset && take_exc) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected take_exc handler=%h epc=%h cause=%0d", handler_addr, epc, cause);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if ({handler_addr, epc, cause} !== e) begin
                    errors++;
                    $display("FAIL sb_take_exc got h=%h epc=%h cause=%0d want h=%h epc=%h cause=%0d",
                             handler_addr, epc, cause, e[EW-1 -: DATA_W], e[2*DATA_W-1 -: DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mem_req, busy, take_exc, ret_valid, in_handler, double_fault} !== 6'b0 ||
            epc !== '0 || cause !== '0 || handler_addr !== '0 || mem_addr !== '0 ||
            pending !== '0 || state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL reset_state mem_req=%b busy=%b epc=%h cause=%h pend=%b st=%0d want all zero",
                     mem_req, busy, epc, cause, pending, state_dbg);
        end
    endtask

    task automatic test_sync_fault();
        do_reset();
        exc_req = 4'b0010; fault_pc = 32'h40; mem_ready = 1'b1; mem_rdata = 32'h100;
        push_exp(32'h100, 32'h40, 1);
        step();
        exc_req = '0;
        checks++;
        if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== 32'hF4 || pending !== 4'b0) begin
            errors++;
            $display("FAIL sync_fetch req=%b busy=%b addr=%h pend=%b want 1 1 f4 0000", mem_req, busy, mem_addr, pending);
        end
        step();
        checks++;
        if (take_exc !== 1'b1 || handler_addr !== 32'h100 || epc !== 32'h40 || cause !== 32'd1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL sync_dispatch take=%b h=%h epc=%h cause=%0d want 1 100 40 1", take_exc, handler_addr, epc, cause);
        end
        step();
        checks++;
        if (take_exc !== 1'b0 || in_handler !== 1'b1 || state_dbg !== S_HAND) begin
            errors++;
            $display("FAIL sync_handler take=%b inh=%b st=%0d want 0 1 3", take_exc, in_handler, state_dbg);
        end
        eret = 1'b1;
        step();
        eret = 1'b0;
        checks++;
        if (ret_valid !== 1'b1 || in_handler !== 1'b0 || state_dbg !== S_IDLE || epc !== 32'h40) begin
            errors++;
            $display("FAIL sync_eret rv=%b inh=%b st=%0d epc=%h want 1 0 0 40", ret_valid, in_handler, state_dbg, epc);
        end
        step();
        checks++;
        if (ret_valid !== 1'b0) begin
            errors++;
            $display("FAIL sync_eret_pulse rv=%b want 0", ret_valid);
        end
    endtask

    task automatic test_masked_irq();
        do_reset();
        instr_boundary = 1'b1; irq_mask = 4'b0000; exc_req = 4'b0100;
        step();
        exc_req = '0;
        checks++;
        if (pending !== 4'b0100 || mem_req !== 1'b0 || state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL masked_hold pend=%b req=%b st=%0d want 0100 0 0", pending, mem_req, state_dbg);
        end
        irq_mask = 4'b0100; instr_boundary = 1'b0;
        step();
        checks++;
        if (pending !== 4'b0100 || mem_req !== 1'b0 || state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL masked_noboundary pend=%b req=%b st=%0d want 0100 0 0", pending, mem_req, state_dbg);
        end
        instr_boundary = 1'b1; fault_pc = 32'h80; mem_ready = 1'b1; mem_rdata = 32'h200;
        push_exp(32'h200, 32'h80, 2);
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hF8 || cause !== 32'd2 || pending !== 4'b0) begin
            errors++;
            $display("FAIL masked_accept req=%b addr=%h cause=%0d pend=%b want 1 f8 2 0000", mem_req, mem_addr, cause, pending);
        end
        step();
        step();
    endtask

    task automatic test_priority_eret();
        do_reset();
        irq_mask = 4'b1000; instr_boundary = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h300;
        fault_pc = 32'h1000; exc_req = 4'b1001;
        push_exp(32'h300, 32'h1000, 0);
        step();
        exc_req = '0;
        checks++;
        if (cause !== 32'd0 || pending !== 4'b1000 || state_dbg !== S_FETCH) begin
            errors++;
            $display("FAIL prio_first cause=%0d pend=%b st=%0d want 0 1000 1", cause, pending, state_dbg);
        end
        step();
        step();
        step();
        checks++;
        if (state_dbg !== S_HAND || mem_req !== 1'b0 || pending !== 4'b1000) begin
            errors++;
            $display("FAIL prio_no_nest st=%0d req=%b pend=%b want 3 0 1000", state_dbg, mem_req, pending);
        end
        fault_pc = 32'h2000; mem_rdata = 32'h3C0; eret = 1'b1;
        push_exp(32'h3C0, 32'h2000, 3);
        step();
        eret = 1'b0;
        checks++;
        if (ret_valid !== 1'b1 || epc !== 32'h1000 || state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL prio_eret rv=%b epc=%h st=%0d want 1 1000 0", ret_valid, epc, state_dbg);
        end
        step();
        checks++;
        if (state_dbg !== S_FETCH || cause !== 32'd3 || mem_addr !== 32'hFC || pending !== 4'b0 || ret_valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_second st=%0d cause=%0d addr=%h pend=%b rv=%b want 1 3 fc 0000 0",
                     state_dbg, cause, mem_addr, pending, ret_valid);
        end
        step();
        step();
    endtask

    task automatic test_stalled_fetch();
        do_reset();
        mem_ready = 1'b0; fault_pc = 32'h44; exc_req = 4'b0001;
        push_exp(32'h104, 32'h44, 0);
        step();
        exc_req = '0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== 32'hF0 || take_exc !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d req=%b busy=%b addr=%h take=%b want 1 1 f0 0",
                         i, mem_req, busy, mem_addr, take_exc);
            end
            step();
        end
        mem_ready = 1'b1; mem_rdata = 32'h104;
        step();
        mem_ready = 1'b0;
        checks++;
        if (take_exc !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_release take=%b busy=%b req=%b want 1 0 0", take_exc, busy, mem_req);
        end
        step();
        checks++;
        if (take_exc !== 1'b0) begin
            errors++;
            $display("FAIL stall_pulse take=%b want 0", take_exc);
        end
    endtask

    task automatic test_double_fault();
        do_reset();
        mem_ready = 1'b1; mem_rdata = 32'h500; fault_pc = 32'h50; exc_req = 4'b0010;
        push_exp(32'h500, 32'h50, 1);
        step();
        exc_req = '0;
        step();
        step();
        exc_req = 4'b0001;
        step();
        exc_req = '0;
        checks++;
        if (double_fault !== 1'b1 || pending !== 4'b0001 || take_exc !== 1'b0 || state_dbg !== S_HAND) begin
            errors++;
            $display("FAIL dfault_flag df=%b pend=%b take=%b st=%0d want 1 0001 0 3",
                     double_fault, pending, take_exc, state_dbg);
        end
        step();
        checks++;
        if (take_exc !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL dfault_no_take take=%b req=%b want 0 0", take_exc, mem_req);
        end
        eret = 1'b1; mem_rdata = 32'h600; fault_pc = 32'h60;
        push_exp(32'h600, 32'h60, 0);
        step();
        eret = 1'b0;
        checks++;
        if (ret_valid !== 1'b1 || double_fault !== 1'b1) begin
            errors++;
            $display("FAIL dfault_eret rv=%b df=%b want 1 1", ret_valid, double_fault);
        end
        step();
        checks++;
        if (state_dbg !== S_FETCH || cause !== 32'd0 || pending !== 4'b0) begin
            errors++;
            $display("FAIL dfault_reentry st=%0d cause=%0d pend=%b want 1 0 0000", state_dbg, cause, pending);
        end
        step();
        step();
        checks++;
        if (double_fault !== 1'b1) begin
            errors++;
            $display("FAIL dfault_sticky df=%b want 1", double_fault);
        end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        mem_ready = 1'b0; fault_pc = 32'h70; exc_req = 4'b0010;
        step();
        exc_req = 4'b1000;
        step();
        exc_req = '0;
        checks++;
        if (mem_req !== 1'b1 || pending !== 4'b1000 || epc !== 32'h70) begin
            errors++;
            $display("FAIL rstmid_pre req=%b pend=%b epc=%h want 1 1000 70", mem_req, pending, epc);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || epc !== '0 || pending !== '0 ||
            state_dbg !== S_IDLE || cause !== '0) begin
            errors++;
            $display("FAIL rstmid_post req=%b busy=%b epc=%h pend=%b st=%0d cause=%0d want all zero",
                     mem_req, busy, epc, pending, state_dbg, cause);
        end
        eret = 1'b1;
        step();
        eret = 1'b0;
        checks++;
        if (ret_valid !== 1'b0 || state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL rstmid_stray_eret rv=%b st=%0d want 0 0", ret_valid, state_dbg);
        end
    endtask

    task automatic test_random();
        do_reset();
        irq_mask = 4'b1111; instr_boundary = 1'b1;
        for (int n = 0; n < 6; n++) begin
            int idx;
            int stall;
            logic [DATA_W-1:0] pc;
            logic [DATA_W-1:0] h;
            idx   = $urandom_range(0, NC - 1);
            stall = $urandom_range(0, 4);
            pc    = {$urandom_range(0, 32'hFFFF), 2'b00};
            h     = $urandom;
            exc_req = NC'(1 << idx); fault_pc = pc; mem_ready = 1'b0;
            push_exp(h, pc, idx);
            step();
            exc_req = '0;
            checks++;
            if (mem_addr !== 32'd240 + 32'(idx * 4)) begin
                errors++;
                $display("FAIL rand_addr n=%0d addr=%h want %h", n, mem_addr, 32'd240 + 32'(idx * 4));
            end
            for (int k = 0; k < stall; k++) step();
            mem_ready = 1'b1; mem_rdata = h;
            step();
            mem_ready = 1'b0;
            step();
            eret = 1'b1;
            step();
            eret = 1'b0;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_sync_fault();
        test_masked_irq();
        test_priority_eret();
        test_stalled_fetch();
        test_double_fault();
        test_reset_mid_fetch();
        test_random();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover remaining=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
